// File: rtl/piso_bit_streamer.sv
// piso_bit_streamer
//
// Parallel-in serial-out stage that feeds a 1-bit serial consumer from a
// word-wide producer. A WIDTH-bit word is taken over a valid/ready handshake
// and emitted one bit per clock with a qualifying valid strobe. An optional
// idle gap of GAP_CYCLES clocks can follow each word so the consumer sees a
// defined idle level between words.
//
// Parameters:
//   WIDTH      bits per word (2..32)
//   MSB_FIRST  1: bit WIDTH-1 goes out first; 0: bit 0 goes out first
//   GAP_CYCLES idle cycles forced after each word (0..15)
//   IDLE_LEVEL level driven on sout whenever sout_valid is low
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous, active-high reset
//   load_data   parallel word, sampled only on an accept edge
//   load_valid  producer has a word on load_data
//   load_ready  block can accept a word this cycle (state/counters only)
//   sout        serial bit (registered)
//   sout_valid  sout carries a data bit this cycle (registered)
//   last_bit    sout is the final bit of its word (registered)
//   busy        a word is shifting or a gap is in progress

module piso_bit_streamer #(
  parameter int unsigned WIDTH      = 8,
  parameter bit          MSB_FIRST  = 1'b1,
  parameter int unsigned GAP_CYCLES = 0,
  parameter bit          IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             last_bit,
  output logic             busy
);

  // Counter widths: the bit counter holds WIDTH-1, the gap counter holds
  // GAP_CYCLES-1 (kept at least one bit wide when no gap is configured).
  localparam int unsigned CntW = $clog2(WIDTH);
  localparam int unsigned GapW = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES);

  localparam logic [CntW-1:0] LastBit   = CntW'(WIDTH - 1);
  localparam logic [CntW-1:0] PenultBit = CntW'(WIDTH - 2);
  localparam logic [GapW-1:0] GapLast   = GapW'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);
  localparam bit              HasGap    = (GAP_CYCLES != 0);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StShift = 2'd1;
  localparam logic [1:0] StGap   = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CntW-1:0]  bit_cnt_q, bit_cnt_d;
  logic [GapW-1:0]  gap_cnt_q, gap_cnt_d;
  logic             sout_q, sout_d;
  logic             sout_valid_q, sout_valid_d;
  logic             last_bit_q, last_bit_d;

  logic             on_last_bit;
  logic             accept;
  logic             load_first;
  logic [WIDTH-1:0] load_rest;
  logic             next_bit;
  logic [WIDTH-1:0] shift_adv;

  // bit_cnt_q is the index (in send order) of the bit currently on sout.
  assign on_last_bit = (state_q == StShift) && (bit_cnt_q == LastBit);

  // Ready depends on state and counters only, so there is no path from
  // load_valid to load_ready. With no gap a new word can be taken while the
  // final bit is on the line, giving back-to-back words with no bubble.
  always_comb begin
    load_ready = 1'b0;
    if (state_q == StIdle) begin
      load_ready = 1'b1;
    end else if (!HasGap && on_last_bit) begin
      load_ready = 1'b1;
    end
  end

  assign accept = load_valid && load_ready;

  // The first bit goes straight into the output register on the accept edge;
  // the shift register keeps only the bits still to be sent, aligned so the
  // next bit always sits at the same end.
  assign load_first = MSB_FIRST ? load_data[WIDTH-1] : load_data[0];
  assign load_rest  = MSB_FIRST ? (load_data << 1) : (load_data >> 1);
  assign next_bit   = MSB_FIRST ? shift_q[WIDTH-1] : shift_q[0];
  assign shift_adv  = MSB_FIRST ? (shift_q << 1) : (shift_q >> 1);

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    sout_d       = IDLE_LEVEL;
    sout_valid_d = 1'b0;
    last_bit_d   = 1'b0;

    case (state_q)
      StIdle: begin
        if (accept) begin
          state_d      = StShift;
          shift_d      = load_rest;
          bit_cnt_d    = '0;
          sout_d       = load_first;
          sout_valid_d = 1'b1;
        end
      end

      StShift: begin
        if (bit_cnt_q == LastBit) begin
          if (HasGap) begin
            state_d   = StGap;
            gap_cnt_d = '0;
          end else if (accept) begin
            // Chain the next word directly behind the final bit.
            state_d      = StShift;
            shift_d      = load_rest;
            bit_cnt_d    = '0;
            sout_d       = load_first;
            sout_valid_d = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end else begin
          shift_d      = shift_adv;
          bit_cnt_d    = bit_cnt_q + 1'b1;
          sout_d       = next_bit;
          sout_valid_d = 1'b1;
          last_bit_d   = (bit_cnt_q == PenultBit);
        end
      end

      StGap: begin
        if (gap_cnt_q == GapLast) begin
          state_d = StIdle;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      gap_cnt_q    <= '0;
      sout_q       <= IDLE_LEVEL;
      sout_valid_q <= 1'b0;
      last_bit_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      sout_q       <= sout_d;
      sout_valid_q <= sout_valid_d;
      last_bit_q   <= last_bit_d;
    end
  end

  assign sout       = sout_q;
  assign sout_valid = sout_valid_q;
  assign last_bit   = last_bit_q;
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_piso_bit_streamer.sv
module tb_piso_bit_streamer;

  localparam int NDut = 4;

  typedef struct packed {
    logic v;
    logic b;
    logic l;
  } exp_t;

  logic            clk = 1'b0;
  logic            reset;
  logic [7:0]      data;
  logic            lv;
  int              cur;
  logic [NDut-1:0] lv_vec, ready_v, sout_v, valid_v, last_v, busy_v;

  exp_t        exp_q[$];
  int          n_checks, n_fail, n_acc;
  logic [31:0] rec;
  int          rec_n, busy_n, run, max_run;

  always #5 clk = ~clk;

  always_comb begin
    lv_vec = '0;
    for (int i = 0; i < NDut; i++) lv_vec[i] = lv && (cur == i);
  end

  piso_bit_streamer #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP_CYCLES(0), .IDLE_LEVEL(1'b0)) dut0 (
    .clk(clk), .reset(reset), .load_data(data), .load_valid(lv_vec[0]),
    .load_ready(ready_v[0]), .sout(sout_v[0]), .sout_valid(valid_v[0]),
    .last_bit(last_v[0]), .busy(busy_v[0])
  );

  piso_bit_streamer #(.WIDTH(8), .MSB_FIRST(1'b0), .GAP_CYCLES(0), .IDLE_LEVEL(1'b1)) dut1 (
    .clk(clk), .reset(reset), .load_data(data), .load_valid(lv_vec[1]),
    .load_ready(ready_v[1]), .sout(sout_v[1]), .sout_valid(valid_v[1]),
    .last_bit(last_v[1]), .busy(busy_v[1])
  );

  piso_bit_streamer #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP_CYCLES(2), .IDLE_LEVEL(1'b0)) dut2 (
    .clk(clk), .reset(reset), .load_data(data), .load_valid(lv_vec[2]),
    .load_ready(ready_v[2]), .sout(sout_v[2]), .sout_valid(valid_v[2]),
    .last_bit(last_v[2]), .busy(busy_v[2])
  );

  piso_bit_streamer #(.WIDTH(5), .MSB_FIRST(1'b0), .GAP_CYCLES(3), .IDLE_LEVEL(1'b1)) dut3 (
    .clk(clk), .reset(reset), .load_data(data[4:0]), .load_valid(lv_vec[3]),
    .load_ready(ready_v[3]), .sout(sout_v[3]), .sout_valid(valid_v[3]),
    .last_bit(last_v[3]), .busy(busy_v[3])
  );

  // Configuration of each instance, as seen by the reference model.
  function automatic int p_w(input int i);
    return (i == 3) ? 5 : 8;
  endfunction

  function automatic bit p_msb(input int i);
    return !(i == 1 || i == 3);
  endfunction

  function automatic int p_gap(input int i);
    return (i == 2) ? 2 : ((i == 3) ? 3 : 0);
  endfunction

  function automatic bit p_idle(input int i);
    return (i == 1 || i == 3);
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %0h expected %0h at %0t", tag, cur, got, exp, $time);
    end
  endtask

  // Reference model: a queue of what the line will show in coming cycles.
  // Each accepted word appends its bits in send order plus its gap cycles;
  // the head of the queue is the current cycle, an empty queue means idle.
  function automatic bit model_ready();
    if (exp_q.size() == 0) return 1'b1;
    return (p_gap(cur) == 0) && (exp_q.size() == 1) && exp_q[0].l;
  endfunction

  task automatic check_outputs();
    exp_t e;
    if (reset) exp_q.delete();
    e = '0;
    e.b = p_idle(cur);
    if (exp_q.size() != 0) e = exp_q[0];
    check_eq("sout_valid", {31'd0, valid_v[cur]}, {31'd0, e.v});
    check_eq("sout", {31'd0, sout_v[cur]}, {31'd0, e.b});
    check_eq("last_bit", {31'd0, last_v[cur]}, {31'd0, e.l});
    check_eq("busy", {31'd0, busy_v[cur]}, {31'd0, exp_q.size() != 0});
    check_eq("load_ready", {31'd0, ready_v[cur]}, {31'd0, model_ready()});
    if (valid_v[cur]) begin
      rec = {rec[30:0], sout_v[cur]};
      rec_n++;
      run++;
      if (run > max_run) max_run = run;
    end else begin
      run = 0;
    end
    if (busy_v[cur]) busy_n++;
  endtask

  task automatic model_edge();
    exp_t e;
    int   w;
    bit   acc;
    w   = p_w(cur);
    acc = lv && model_ready() && !reset;
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    if (reset) exp_q.delete();
    if (acc) begin
      n_acc++;
      for (int k = 0; k < w; k++) begin
        e.v = 1'b1;
        e.b = data[p_msb(cur) ? (w - 1 - k) : k];
        e.l = (k == w - 1);
        exp_q.push_back(e);
      end
      for (int g = 0; g < p_gap(cur); g++) begin
        e.v = 1'b0;
        e.b = p_idle(cur);
        e.l = 1'b0;
        exp_q.push_back(e);
      end
    end
  endtask

  // Called at posedge+1: check this cycle, advance the model, move on.
  task automatic tick();
    #1;
    check_outputs();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic start_phase(input int i);
    cur   = i;
    lv    = 1'b0;
    reset = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    reset   = 1'b0;
    rec     = '0;
    rec_n   = 0;
    busy_n  = 0;
    run     = 0;
    max_run = 0;
    n_acc   = 0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    cur      = 0;
    reset    = 1'b1;
    lv       = 1'b0;
    data     = '0;
    #3;
    for (int i = 0; i < NDut; i++) begin
      cur = i;
      check_eq("rst_ready", {31'd0, ready_v[i]}, 32'd1);
      check_eq("rst_valid", {31'd0, valid_v[i]}, 32'd0);
      check_eq("rst_sout", {31'd0, sout_v[i]}, {31'd0, p_idle(i)});
      check_eq("rst_last", {31'd0, last_v[i]}, 32'd0);
      check_eq("rst_busy", {31'd0, busy_v[i]}, 32'd0);
    end

    // 0x1B MSB first
    start_phase(0);
    lv = 1'b1; data = 8'h1B; tick();
    lv = 1'b0;
    repeat (10) begin data = 8'($urandom); tick(); end
    check_eq("msb_stream", rec & 32'hFF, 32'h1B);
    check_eq("msb_count", rec_n, 8);

    // 0x1B LSB first: 1,1,0,1,1,0,0,0
    start_phase(1);
    lv = 1'b1; data = 8'h1B; tick();
    lv = 1'b0;
    repeat (11) tick();
    check_eq("lsb_stream", rec & 32'hFF, 32'hD8);
    check_eq("lsb_busy_cycles", busy_n, 8);

    // back-to-back, no gap
    start_phase(0);
    lv = 1'b1; data = 8'hFF; tick();
    lv = 1'b0;
    repeat (7) tick();
    lv = 1'b1; data = 8'h00; tick();
    lv = 1'b0;
    repeat (10) tick();
    check_eq("b2b_stream", rec & 32'hFFFF, 32'hFF00);
    check_eq("b2b_run", max_run, 16);

    // back-to-back with a 2-cycle gap, valid held high
    start_phase(2);
    lv = 1'b1; data = 8'hFF; tick();
    data = 8'h00;
    for (int t = 0; t < 30 && n_acc < 2; t++) tick();
    check_eq("gap_accept_bound", n_acc, 2);
    lv = 1'b0;
    repeat (12) tick();
    check_eq("gap_stream", rec & 32'hFFFF, 32'hFF00);
    check_eq("gap_count", rec_n, 16);
    check_eq("gap_run", max_run, 8);

    // reset in the middle of 0xF0
    start_phase(0);
    lv = 1'b1; data = 8'hF0; tick();
    lv = 1'b0;
    repeat (3) tick();
    check_eq("pre_rst_bits", rec & 32'h7, 32'h7);
    check_eq("pre_rst_count", rec_n, 3);
    #2;
    reset = 1'b1;
    #1;
    check_eq("async_sout", {31'd0, sout_v[0]}, 32'd0);
    check_eq("async_valid", {31'd0, valid_v[0]}, 32'd0);
    check_eq("async_busy", {31'd0, busy_v[0]}, 32'd0);
    check_eq("async_last", {31'd0, last_v[0]}, 32'd0);
    check_eq("async_ready", {31'd0, ready_v[0]}, 32'd1);
    exp_q.delete();
    @(posedge clk);
    #1;
    tick();
    reset = 1'b0;
    rec_n = 0;
    repeat (10) tick();
    check_eq("post_rst_count", rec_n, 0);

    // 0xAA with load_data toggling and valid held
    start_phase(0);
    lv = 1'b1; data = 8'hAA; tick();
    for (int t = 0; t < 20 && n_acc < 2; t++) begin
      data = 8'($urandom);
      tick();
    end
    check_eq("hold_accept_bound", n_acc, 2);
    lv = 1'b0;
    repeat (12) tick();
    check_eq("hold_first_word", (rec >> 8) & 32'hFF, 32'hAA);
    check_eq("hold_count", rec_n, 16);

    // randomized traffic on every configuration, with occasional resets
    for (int i = 0; i < NDut; i++) begin
      start_phase(i);
      repeat (250) begin
        lv    = ($urandom_range(0, 2) != 0);
        data  = 8'($urandom);
        reset = ($urandom_range(0, 99) == 0);
        tick();
      end
      reset = 1'b0;
      lv    = 1'b0;
      repeat (20) tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
